// File: rtl/remote_comm_pkg.sv
// rtl/remote_comm_pkg.sv - shared types and constants for the remote command link
package remote_comm_pkg;
  typedef enum logic {WAIT_HIGH, WAIT_LOW} rx_state_t;
  localparam logic [7:0] ACK_BYTE = 8'hA5;
  localparam int DEFAULT_TIMEOUT_CLKS = 65536;
  localparam int DEFAULT_BAUD_CLKS = 2604;
endpackage

// File: rtl/uart_cmd_rcvr_if.sv
// rtl/uart_cmd_rcvr_if.sv - command/response handshake between receiver and command processor
interface uart_cmd_rcvr_if;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        cmd_drop;
  logic [7:0]  resp;
  logic        snd_resp;
  logic        resp_busy;
  logic        resp_sent;

  modport master (input cmd, cmd_rdy, cmd_drop, resp_busy, resp_sent,
                  output clr_cmd_rdy, resp, snd_resp);
  modport slave (output cmd, cmd_rdy, cmd_drop, resp_busy, resp_sent,
                 input clr_cmd_rdy, resp, snd_resp);
endinterface

// File: rtl/uart_cmd_rcvr_uart.sv
// rtl/uart_cmd_rcvr_uart.sv - full-duplex 8N1 UART transceiver
module uart_cmd_rcvr_uart #(
  parameter int BAUD_CLKS = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  output logic       TX,
  output logic       rx_rdy,
  input  logic       clr_rx_rdy,
  output logic [7:0] rx_data,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done
);
  localparam int BW = $clog2(BAUD_CLKS);

  logic          rx_s1, rx_s2, rx_busy;
  logic [BW-1:0] rx_cnt;
  logic [3:0]    rx_bits;
  logic [9:0]    rx_shift;

  // Samples start, 8 data and stop bits at mid-bit; first sample is half a bit after the falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_busy  <= 1'b0;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_shift <= '0;
      rx_rdy   <= 1'b0;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      if (clr_rx_rdy) rx_rdy <= 1'b0;
      if (!rx_busy) begin
        if (!rx_s2) begin
          rx_busy <= 1'b1;
          rx_cnt  <= BW'(BAUD_CLKS / 2);
          rx_bits <= '0;
        end
      end else if (rx_cnt == '0) begin
        rx_shift <= {rx_s2, rx_shift[9:1]};
        rx_cnt   <= BW'(BAUD_CLKS - 1);
        rx_bits  <= rx_bits + 4'd1;
        if (rx_bits == 4'd9) begin
          rx_busy <= 1'b0;
          rx_rdy  <= 1'b1;
        end
      end else begin
        rx_cnt <= rx_cnt - 1'b1;
      end
    end
  end

  assign rx_data = rx_shift[8:1];

  logic          tx_busy;
  logic [BW-1:0] tx_cnt;
  logic [3:0]    tx_bits;
  logic [9:0]    tx_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy  <= 1'b0;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_shift <= '1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (!tx_busy) begin
        if (trmt) begin
          tx_shift <= {1'b1, tx_data, 1'b0};
          tx_busy  <= 1'b1;
          tx_cnt   <= BW'(BAUD_CLKS - 1);
          tx_bits  <= '0;
        end
      end else if (tx_cnt == '0) begin
        tx_shift <= {1'b1, tx_shift[9:1]};
        tx_cnt   <= BW'(BAUD_CLKS - 1);
        tx_bits  <= tx_bits + 4'd1;
        if (tx_bits == 4'd9) begin
          tx_busy <= 1'b0;
          tx_done <= 1'b1;
        end
      end else begin
        tx_cnt <= tx_cnt - 1'b1;
      end
    end
  end

  assign TX = tx_shift[0];
endmodule

// File: rtl/uart_cmd_rcvr.sv
// rtl/uart_cmd_rcvr.sv - assembles two received bytes into a 16-bit command and sends response bytes
module uart_cmd_rcvr
  import remote_comm_pkg::*;
#(
  parameter int TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS,
  parameter int BAUD_CLKS    = DEFAULT_BAUD_CLKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic RX,
  output logic TX,
  uart_cmd_rcvr_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_CLKS);

  logic        rx_rdy, clr_rx_rdy, trmt, tx_done;
  logic [7:0]  rx_data, tx_data, high;
  rx_state_t   state;
  logic [TW-1:0] timer;
  logic [15:0] cmd_q;
  logic        cmd_rdy_q, cmd_drop_q, resp_busy_q, resp_sent_q;
  logic        rx_byte;

  uart_cmd_rcvr_uart #(.BAUD_CLKS(BAUD_CLKS)) u_uart (
    .clk(clk), .rst_n(rst_n), .RX(RX), .TX(TX),
    .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy), .rx_data(rx_data),
    .trmt(trmt), .tx_data(tx_data), .tx_done(tx_done)
  );

  // clr_rx_rdy is registered, so rx_rdy is still high the cycle after a capture; mask it then.
  assign rx_byte = rx_rdy && !clr_rx_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_HIGH;
      timer      <= '0;
      high       <= '0;
      cmd_q      <= '0;
      cmd_rdy_q  <= 1'b0;
      cmd_drop_q <= 1'b0;
      clr_rx_rdy <= 1'b0;
    end else begin
      clr_rx_rdy <= 1'b0;
      cmd_drop_q <= 1'b0;
      if (bus.clr_cmd_rdy) cmd_rdy_q <= 1'b0;
      case (state)
        WAIT_HIGH: if (rx_byte) begin
          high       <= rx_data;
          clr_rx_rdy <= 1'b1;
          cmd_rdy_q  <= 1'b0;
          timer      <= '0;
          state      <= WAIT_LOW;
        end
        WAIT_LOW: begin
          timer <= timer + 1'b1;
          if (rx_byte) begin
            cmd_q      <= {high, rx_data};
            clr_rx_rdy <= 1'b1;
            cmd_rdy_q  <= 1'b1;
            state      <= WAIT_HIGH;
          end else if (timer == TW'(TIMEOUT_CLKS - 1)) begin
            cmd_drop_q <= 1'b1;
            state      <= WAIT_HIGH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data     <= '0;
      trmt        <= 1'b0;
      resp_busy_q <= 1'b0;
      resp_sent_q <= 1'b0;
    end else begin
      trmt        <= 1'b0;
      resp_sent_q <= 1'b0;
      if (tx_done) begin
        resp_busy_q <= 1'b0;
        resp_sent_q <= 1'b1;
      end else if (bus.snd_resp && !resp_busy_q) begin
        tx_data     <= bus.resp;
        trmt        <= 1'b1;
        resp_busy_q <= 1'b1;
      end
    end
  end

  assign bus.cmd       = cmd_q;
  assign bus.cmd_rdy   = cmd_rdy_q;
  assign bus.cmd_drop  = cmd_drop_q;
  assign bus.resp_busy = resp_busy_q;
  assign bus.resp_sent = resp_sent_q;
endmodule

// File: tb/tb_uart_cmd_rcvr.sv
// tb/tb_uart_cmd_rcvr.sv - scoreboard bench for uart_cmd_rcvr
module tb_uart_cmd_rcvr;
  import remote_comm_pkg::*;

  localparam int BAUD = 16;
  localparam int TMO  = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx_line = 1'b1;
  logic tx_line;
  int   pass_cnt = 0;
  int   check_cnt = 0;
  int   drop_cnt = 0;
  int   sent_cnt = 0;
  int   frames_seen = 0;
  int   tx_bytes_seen = 0;
  logic [15:0] cmd_exp_q[$];
  logic [7:0]  tx_exp_q[$];

  uart_cmd_rcvr_if bus();

  uart_cmd_rcvr #(.TIMEOUT_CLKS(TMO), .BAUD_CLKS(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(rx_line), .TX(tx_line), .bus(bus)
  );

  always #5 clk = ~clk;

  // Command scoreboard: a new frame shows up as cmd_rdy rising or cmd changing while ready.
  initial begin
    logic prev_rdy;
    logic [15:0] prev_cmd, exp;
    prev_rdy = 1'b0;
    prev_cmd = '0;
    forever begin
      @(negedge clk);
      if (bus.cmd_drop === 1'b1) drop_cnt++;
      if (bus.resp_sent === 1'b1) sent_cnt++;
      if (rst_n && bus.cmd_rdy === 1'b1 && (!prev_rdy || bus.cmd !== prev_cmd)) begin
        frames_seen++;
        check_cnt++;
        if (cmd_exp_q.size() == 0) begin
          $display("FAIL frame_unexpected: cmd=%h with nothing expected", bus.cmd);
        end else begin
          exp = cmd_exp_q.pop_front();
          if (bus.cmd !== exp) $display("FAIL frame_cmd: got %h expected %h", bus.cmd, exp);
          else pass_cnt++;
        end
      end
      prev_rdy = (bus.cmd_rdy === 1'b1);
      prev_cmd = bus.cmd;
    end
  end

  // TX decoder and response scoreboard.
  initial begin
    logic [7:0] b, exp;
    forever begin
      @(negedge clk);
      if (rst_n && tx_line === 1'b0) begin
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BAUD) @(negedge clk);
          b[i] = tx_line;
        end
        repeat (BAUD) @(negedge clk);
        tx_bytes_seen++;
        check_cnt++;
        if (tx_exp_q.size() == 0) begin
          $display("FAIL tx_unexpected: byte %h with nothing expected", b);
        end else begin
          exp = tx_exp_q.pop_front();
          if (b !== exp || tx_line !== 1'b1)
            $display("FAIL tx_byte: got %h stop=%b expected %h stop=1", b, tx_line, exp);
          else pass_cnt++;
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_line = f[i];
      repeat (BAUD - 1) @(negedge clk);
    end
  endtask

  task automatic wait_rx_rdy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12 * BAUD; i++) begin
      @(negedge clk);
      if (dut.rx_rdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({bus.cmd, bus.cmd_rdy, bus.cmd_drop, bus.resp_busy, bus.resp_sent, tx_line} !== {16'h0, 5'b00001})
      $display("FAIL reset_in: cmd=%h rdy=%b drop=%b busy=%b sent=%b tx=%b required 0000 0 0 0 0 1",
               bus.cmd, bus.cmd_rdy, bus.cmd_drop, bus.resp_busy, bus.resp_sent, tx_line);
    else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_cnt++;
    if ({bus.cmd, bus.cmd_rdy, tx_line} !== {16'h0, 2'b01})
      $display("FAIL reset_out: cmd=%h rdy=%b tx=%b required 0000 0 1", bus.cmd, bus.cmd_rdy, tx_line);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    cmd_exp_q.push_back(16'hABCD);
    send_byte(8'hAB);
    fork
      send_byte(8'hCD);
      begin
        wait_rx_rdy(ok);
        check_cnt++;
        if (!ok || bus.cmd_rdy !== 1'b0)
          $display("FAIL b2b_pre: rx_rdy_seen=%b cmd_rdy=%b required 1 0", ok, bus.cmd_rdy);
        else pass_cnt++;
        @(negedge clk);
        check_cnt++;
        if (bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'hABCD)
          $display("FAIL b2b_latency: cmd_rdy=%b cmd=%h required 1 abcd", bus.cmd_rdy, bus.cmd);
        else pass_cnt++;
      end
    join
    check_cnt++;
    if (drop_cnt !== 0) $display("FAIL b2b_drop: drops=%0d required 0", drop_cnt);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    send_byte(8'h12);
    repeat (TMO + 4) @(negedge clk);
    check_cnt++;
    if (drop_cnt !== 1 || bus.cmd !== 16'hABCD || bus.cmd_rdy !== 1'b0)
      $display("FAIL timeout_drop: drops=%0d cmd=%h rdy=%b required 1 abcd 0", drop_cnt, bus.cmd, bus.cmd_rdy);
    else pass_cnt++;
    send_byte(8'h34);
    repeat (4) @(negedge clk);
    check_cnt++;
    if (drop_cnt !== 1 || bus.cmd !== 16'hABCD || bus.cmd_rdy !== 1'b0)
      $display("FAIL timeout_lone: drops=%0d cmd=%h rdy=%b required 1 abcd 0", drop_cnt, bus.cmd, bus.cmd_rdy);
    else pass_cnt++;
    repeat (TMO + 4) @(negedge clk);
    check_cnt++;
    if (drop_cnt !== 2 || bus.cmd !== 16'hABCD)
      $display("FAIL timeout_second: drops=%0d cmd=%h required 2 abcd", drop_cnt, bus.cmd);
    else pass_cnt++;
  endtask

  task automatic test_clr_race();
    bit ok;
    cmd_exp_q.push_back(16'h1234);
    send_byte(8'h12);
    fork
      send_byte(8'h34);
      begin
        wait_rx_rdy(ok);
        bus.clr_cmd_rdy = 1'b1;
        @(negedge clk);
        bus.clr_cmd_rdy = 1'b0;
        check_cnt++;
        if (!ok || bus.cmd_rdy !== 1'b1 || bus.cmd !== 16'h1234)
          $display("FAIL clr_race_set: rx_rdy_seen=%b rdy=%b cmd=%h required 1 1 1234", ok, bus.cmd_rdy, bus.cmd);
        else pass_cnt++;
      end
    join
    bus.clr_cmd_rdy = 1'b1;
    @(negedge clk);
    bus.clr_cmd_rdy = 1'b0;
    check_cnt++;
    if (bus.cmd_rdy !== 1'b0 || bus.cmd !== 16'h1234)
      $display("FAIL clr_later: rdy=%b cmd=%h required 0 1234", bus.cmd_rdy, bus.cmd);
    else pass_cnt++;
  endtask

  task automatic test_overwrite();
    int f0;
    f0 = frames_seen;
    cmd_exp_q.push_back(16'h5555);
    cmd_exp_q.push_back(16'hAAAA);
    send_byte(8'h55);
    send_byte(8'h55);
    send_byte(8'hAA);
    send_byte(8'hAA);
    repeat (4) @(negedge clk);
    check_cnt++;
    if (bus.cmd !== 16'hAAAA || bus.cmd_rdy !== 1'b1 || frames_seen - f0 !== 2 || cmd_exp_q.size() != 0)
      $display("FAIL overwrite: cmd=%h rdy=%b frames=%0d required aaaa 1 2", bus.cmd, bus.cmd_rdy, frames_seen - f0);
    else pass_cnt++;
  endtask

  task automatic test_response();
    bit ok;
    tx_exp_q.push_back(ACK_BYTE);
    @(negedge clk);
    bus.resp = ACK_BYTE;
    bus.snd_resp = 1'b1;
    @(negedge clk);
    bus.snd_resp = 1'b0;
    @(negedge clk);
    bus.resp = 8'hFF;
    bus.snd_resp = 1'b1;
    @(negedge clk);
    bus.snd_resp = 1'b0;
    check_cnt++;
    if (bus.resp_busy !== 1'b1) $display("FAIL resp_busy_set: busy=%b required 1", bus.resp_busy);
    else pass_cnt++;
    ok = 1'b0;
    for (int i = 0; i < 14 * BAUD; i++) begin
      if (sent_cnt != 0) begin
        ok = 1'b1;
        break;
      end
      check_cnt++;
      if (bus.resp_busy !== 1'b1) $display("FAIL resp_busy_hold: busy=%b required 1", bus.resp_busy);
      else pass_cnt++;
      @(negedge clk);
    end
    check_cnt++;
    if (!ok || bus.resp_busy !== 1'b0)
      $display("FAIL resp_done: sent_seen=%b busy=%b required 1 0", ok, bus.resp_busy);
    else pass_cnt++;
    repeat (12 * BAUD) @(negedge clk);
    check_cnt++;
    if (sent_cnt !== 1 || tx_bytes_seen !== 1 || tx_exp_q.size() != 0 || tx_line !== 1'b1)
      $display("FAIL resp_single: sent=%0d bytes=%0d tx=%b required 1 1 1", sent_cnt, tx_bytes_seen, tx_line);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    send_byte(8'h77);
    fork
      send_byte(8'h88);
      begin
        repeat (4 * BAUD) @(negedge clk);
        rst_n = 1'b0;
      end
    join
    check_cnt++;
    if ({bus.cmd, bus.cmd_rdy, bus.cmd_drop, bus.resp_busy, bus.resp_sent, tx_line} !== {16'h0, 5'b00001})
      $display("FAIL reset_mid: cmd=%h rdy=%b drop=%b busy=%b sent=%b tx=%b required 0000 0 0 0 0 1",
               bus.cmd, bus.cmd_rdy, bus.cmd_drop, bus.resp_busy, bus.resp_sent, tx_line);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    cmd_exp_q.push_back(16'h0F0F);
    send_byte(8'h0F);
    send_byte(8'h0F);
    repeat (4) @(negedge clk);
    check_cnt++;
    if (bus.cmd !== 16'h0F0F || bus.cmd_rdy !== 1'b1 || cmd_exp_q.size() != 0)
      $display("FAIL reset_recover: cmd=%h rdy=%b pending=%0d required 0f0f 1 0", bus.cmd, bus.cmd_rdy, cmd_exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    bus.clr_cmd_rdy = 1'b0;
    bus.resp = 8'h00;
    bus.snd_resp = 1'b0;
    test_reset();
    test_back_to_back();
    test_timeout();
    test_clr_race();
    test_overwrite();
    test_response();
    test_reset_mid_frame();
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule

// File: doc/uart_cmd_rcvr.md
Name: uart_cmd_rcvr

Overview:
Robot-side counterpart of the remote command link. It receives a 16-bit command sent as two UART bytes, high byte first, and presents it as a single word with a ready flag. It also transmits an 8-bit response byte, such as an ack, back over TX. It sits between the board's RX/TX pins and the command processor, and wraps the team's full-duplex UART.

Parameters:
TIMEOUT_CLKS, 65536, max clocks allowed between high-byte capture and low-byte arrival before the partial frame is discarded (must be >1).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
RX  input  1  UART serial in, from the remote
TX  output  1  UART serial out, to the remote
cmd  output  16  last complete command, {high byte, low byte}
cmd_rdy  output  1  complete command available in cmd
clr_cmd_rdy  input  1  consumer acknowledge; clears cmd_rdy
cmd_drop  output  1  one-cycle pulse: partial frame discarded on timeout
resp  input  8  response byte to transmit
snd_resp  input  1  one-cycle request to transmit resp
resp_busy  output  1  response transmission in progress
resp_sent  output  1  one-cycle pulse when the response stop bit is complete

Behaviour:
- Reset is async, active-low; clock is clk. At reset: cmd=16'h0000, cmd_rdy=0, cmd_drop=0, resp_busy=0, resp_sent=0, TX=1 (idle), FSM=WAIT_HIGH, timer=0, high-byte holding register=0.
- FSM has two states: WAIT_HIGH and WAIT_LOW.
- WAIT_HIGH, UART rx_rdy=1:
  - store rx_data in the high holding register;
  - pulse clr_rx_rdy for one cycle;
  - clear cmd_rdy;
  - zero the timer;
  - go to WAIT_LOW.
- WAIT_LOW: the timer increments every clock.
  - rx_rdy=1: load cmd <= {holding, rx_data} in one cycle, pulse clr_rx_rdy, set cmd_rdy (visible the next cycle), go to WAIT_HIGH.
  - Timer reaches TIMEOUT_CLKS-1 with no rx_rdy: pulse cmd_drop for one cycle, go to WAIT_HIGH. cmd and cmd_rdy are left unchanged.
  - rx_rdy and timeout in the same cycle: the byte wins; the frame completes and there is no cmd_drop.
- cmd updates only on a complete frame. A partial or dropped frame never alters cmd.
- Latency is one clk from the low byte's rx_rdy to cmd_rdy=1.
- cmd_rdy clears on clr_cmd_rdy or on arrival of a new high byte. If clr_cmd_rdy coincides with frame completion, set wins and cmd_rdy=1.
- An unacknowledged cmd_rdy does not block reception; the next complete frame overwrites cmd.
- Response path:
  - snd_resp while resp_busy=0: drive UART trmt for one cycle with tx_data=resp, registered at request time; set resp_busy.
  - UART tx_done: clear resp_busy and pulse resp_sent for one cycle.
  - snd_resp while resp_busy=1 is ignored; the in-flight byte is not corrupted.
- Receive and transmit run independently and may overlap.
- Reset mid-frame discards the partial frame and mid-transmission aborts the transmission; all outputs return to reset values.

Decomposition:
- Shared package (remote_comm_pkg):
  - rx FSM state enum {WAIT_HIGH, WAIT_LOW};
  - ACK byte constant 8'hA5;
  - default TIMEOUT_CLKS constant.
- Single sub-module: the existing UART transceiver, providing RX/TX, rx_rdy, clr_rx_rdy, rx_data, trmt, tx_data and tx_done.
- Timer width is $clog2(TIMEOUT_CLKS).

Test Plan:
- Bench drives RX with bytes 8'hAB then 8'hCD, back to back -> cmd=16'hABCD, cmd_rdy=1 one clk after the second rx_rdy, no cmd_drop.
- With cmd=16'hABCD held and cmd_rdy=1, send 8'h12, wait TIMEOUT_CLKS clocks, then send 8'h34 alone -> a single cmd_drop pulse; cmd stays 16'hABCD; cmd_rdy=0 (cleared by the high byte). The lone 8'h34 is treated as a new high byte.
- Send 16'h1234; assert clr_cmd_rdy in the same cycle the low byte completes -> cmd_rdy=1. A later clr_cmd_rdy -> cmd_rdy=0.
- Send two frames 16'h5555 and 16'hAAAA with no clr_cmd_rdy -> cmd=16'hAAAA; cmd_rdy stays 1 after the second frame.
- snd_resp with resp=8'hA5, then snd_resp with resp=8'hFF two cycles later -> TX carries only 8'hA5; resp_busy stays high until one resp_sent pulse, then goes low.
- Assert rst_n=0 mid-low-byte, then release and send 16'h0F0F -> all outputs at reset values during reset; the post-reset frame gives cmd=16'h0F0F and cmd_rdy=1.
